// File: rtl/pdu_inbuf_if.sv
// pdu_inbuf_if: upstream entry handshake plus the to_pdubuf read side.
// slave = the buffer itself; master = whoever drives the buffer (issue/pdu).
interface pdu_inbuf_if #(
    parameter int NUM_LQ    = 8,
    parameter int LQADDR_BW = 3,
    parameter int OPCODE_BW = 4,
    parameter int PTR_BW    = 2
);
    logic                 in_valid;
    logic [OPCODE_BW-1:0] in_opcode;
    logic [NUM_LQ-1:0]    in_lqlist;
    logic                 in_ready;
    logic                 in_drop;
    logic                 take_in;
    logic                 to_pdubuf_empty;
    logic [OPCODE_BW-1:0] out_opcode;
    logic [NUM_LQ-1:0]    out_lqlist;
    logic [LQADDR_BW-1:0] out_first_lqidx;
    logic [PTR_BW:0]      count;

    modport slave (
        input  in_valid, in_opcode, in_lqlist, take_in,
        output in_ready, in_drop, to_pdubuf_empty,
        output out_opcode, out_lqlist, out_first_lqidx, count
    );

    modport master (
        output in_valid, in_opcode, in_lqlist, take_in,
        input  in_ready, in_drop, to_pdubuf_empty,
        input  out_opcode, out_lqlist, out_first_lqidx, count
    );
endinterface

// File: rtl/pdu_inbuf.sv
// pdu_inbuf: circular FIFO of (opcode, lqlist) entries feeding pdu_ctrl.
// Ports: clk, rst_n (async, active-low), bus (pdu_inbuf_if.slave).
module pdu_inbuf #(
    parameter int NUM_LQ    = 8,
    parameter int LQADDR_BW = 3,
    parameter int OPCODE_BW = 4,
    parameter int DEPTH     = 4,
    parameter int PTR_BW    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    pdu_inbuf_if.slave   bus
);
    localparam logic [PTR_BW:0] FULL_CNT = (PTR_BW + 1)'(DEPTH);

    logic [OPCODE_BW-1:0] opc_mem [DEPTH];
    logic [NUM_LQ-1:0]    lq_mem  [DEPTH];
    logic [PTR_BW-1:0]    wr_ptr;
    logic [PTR_BW-1:0]    rd_ptr;
    logic [PTR_BW:0]      count;
    logic                 drop_q;

    logic                 empty;
    logic                 accept;
    logic                 push;
    logic                 drop;
    logic                 pop;
    logic [OPCODE_BW-1:0] head_opc;
    logic [NUM_LQ-1:0]    head_lq;
    logic [LQADDR_BW-1:0] first_idx;

    assign empty  = (count == '0);
    assign accept = bus.in_valid & (count != FULL_CNT);
    assign push   = accept & (|bus.in_lqlist);
    // A zero lqlist would read as "last LQ" downstream, so it is swallowed.
    assign drop   = accept & ~(|bus.in_lqlist);
    assign pop    = bus.take_in & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                opc_mem[i] <= '0;
                lq_mem[i]  <= '0;
            end
        end else begin
            drop_q <= drop;
            if (push) begin
                opc_mem[wr_ptr] <= bus.in_opcode;
                lq_mem[wr_ptr]  <= bus.in_lqlist;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is masked while empty so stale storage never leaks out.
    assign head_opc = empty ? '0 : opc_mem[rd_ptr];
    assign head_lq  = empty ? '0 : lq_mem[rd_ptr];

    // Lowest set bit wins: scan downward so the last hit is the lowest.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_LQ - 1; i >= 0; i--) begin
            if (head_lq[i]) begin
                first_idx = LQADDR_BW'(i);
            end
        end
    end

    assign bus.in_ready        = (count != FULL_CNT);
    assign bus.in_drop         = drop_q;
    assign bus.to_pdubuf_empty = empty;
    assign bus.out_opcode      = head_opc;
    assign bus.out_lqlist      = head_lq;
    assign bus.out_first_lqidx = first_idx;
    assign bus.count           = count;
endmodule

// File: tb/tb_pdu_inbuf.sv
// tb_pdu_inbuf: directed stimulus with a scoreboard queue of expected heads.
// A negedge monitor compares the head whenever a pop is requested.
module tb_pdu_inbuf;
    typedef struct {
        logic [3:0] op;
        logic [7:0] lq;
        logic [2:0] idx;
    } sb_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   mcount;
    sb_t  exp_q[$];

    pdu_inbuf_if #(.NUM_LQ(8), .LQADDR_BW(3), .OPCODE_BW(4), .PTR_BW(2)) bus();

    pdu_inbuf #(
        .NUM_LQ(8), .LQADDR_BW(3), .OPCODE_BW(4), .DEPTH(4), .PTR_BW(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // Scoreboard monitor: a pop happens at the next posedge whenever
    // take_in is high and the model holds entries.
    always @(negedge clk) begin
        if (rst_n && bus.take_in && exp_q.size() > 0) begin
            sb_t e;
            e = exp_q.pop_front();
            check("mon_empty", int'(bus.to_pdubuf_empty), 0);
            check("mon_opcode", int'(bus.out_opcode), int'(e.op));
            check("mon_lqlist", int'(bus.out_lqlist), int'(e.lq));
            check("mon_first_lqidx", int'(bus.out_first_lqidx), int'(e.idx));
        end
    end

    // One clock with the given inputs; expected entries enter the queue
    // only after the edge so the monitor sees pre-edge state.
    task automatic cyc(input logic v, input logic [3:0] op,
                       input logic [7:0] lq, input logic [2:0] idx,
                       input logic tk);
        logic acc;
        logic pu;
        logic po;
        sb_t  e;
        bus.in_valid  = v;
        bus.in_opcode = op;
        bus.in_lqlist = lq;
        bus.take_in   = tk;
        @(posedge clk);
        acc = v && (mcount != 4);
        pu  = acc && (lq != 8'h00);
        po  = tk && (mcount != 0);
        if (pu) begin
            e.op  = op;
            e.lq  = lq;
            e.idx = idx;
            exp_q.push_back(e);
        end
        mcount = mcount + (pu ? 1 : 0) - (po ? 1 : 0);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_lqlist = '0;
        bus.take_in   = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 8'h00, 3'd0, 1'b0);
    endtask

    task automatic pop1();
        cyc(1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    endtask

    task automatic check_state(input string tag, input int cnt,
                               input int emp, input int rdy);
        check({tag, "_count"}, int'(bus.count), cnt);
        check({tag, "_empty"}, int'(bus.to_pdubuf_empty), emp);
        check({tag, "_ready"}, int'(bus.in_ready), rdy);
    endtask

    task automatic check_zero_head(input string tag);
        check({tag, "_opcode"}, int'(bus.out_opcode), 0);
        check({tag, "_lqlist"}, int'(bus.out_lqlist), 0);
        check({tag, "_idx"}, int'(bus.out_first_lqidx), 0);
        check({tag, "_drop"}, int'(bus.in_drop), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] fill_lq  [4];
    logic [2:0] fill_idx [4];
    logic [7:0] wl;

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        mcount        = 0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_lqlist = '0;
        bus.take_in   = 1'b0;
        rst_n         = 1'b0;
        #12;
        check_state("reset", 0, 1, 1);
        check_zero_head("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pop1();
        check_state("pop_empty", 0, 1, 1);

        cyc(1'b1, 4'h3, 8'h28, 3'd3, 1'b0);
        check_state("push1", 1, 0, 1);
        check("push1_lqlist", int'(bus.out_lqlist), 'h28);
        check("push1_idx", int'(bus.out_first_lqidx), 3);
        pop1();
        check_state("pop1", 0, 1, 1);

        fill_lq  = '{8'h01, 8'h02, 8'h04, 8'h80};
        fill_idx = '{3'd0, 3'd1, 3'd2, 3'd7};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'(i + 1), fill_lq[i], fill_idx[i], 1'b0);
        end
        check_state("full", 4, 0, 0);
        cyc(1'b1, 4'h9, 8'h10, 3'd4, 1'b0);
        check_state("full_refuse", 4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            pop1();
        end
        check_state("drain", 0, 1, 1);

        cyc(1'b1, 4'h5, 8'h06, 3'd1, 1'b0);
        cyc(1'b1, 4'h6, 8'h00, 3'd0, 1'b0);
        check("drop_pulse", int'(bus.in_drop), 1);
        check_state("drop", 1, 0, 1);
        idle();
        check("drop_clear", int'(bus.in_drop), 0);
        check_state("drop_after", 1, 0, 1);
        pop1();
        check_state("drop_pop", 0, 1, 1);

        fill_lq  = '{8'h30, 8'h0C, 8'h81, 8'h40};
        fill_idx = '{3'd4, 3'd2, 3'd0, 3'd6};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'(i + 8), fill_lq[i], fill_idx[i], 1'b0);
        end
        check_state("full2", 4, 0, 0);
        cyc(1'b1, 4'h7, 8'hFF, 3'd0, 1'b1);
        check_state("full_pushpop", 3, 0, 1);
        check("full_pushpop_drop", int'(bus.in_drop), 0);
        pop1();
        check_state("two_left", 2, 0, 1);
        for (int i = 0; i < 10; i++) begin
            wl = 8'h80 >> (i % 8);
            cyc(1'b1, 4'(i), wl, 3'(7 - (i % 8)), 1'b1);
            check("wrap_count", int'(bus.count), 2);
        end
        pop1();
        pop1();
        check_state("wrap_drain", 0, 1, 1);

        cyc(1'b1, 4'h1, 8'h11, 3'd0, 1'b0);
        cyc(1'b1, 4'h2, 8'h22, 3'd1, 1'b0);
        cyc(1'b1, 4'h3, 8'h44, 3'd2, 1'b0);
        check_state("pre_reset", 3, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_reset", 0, 1, 1);
        check_zero_head("async_reset");
        exp_q.delete();
        mcount = 0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 4'hC, 8'h0A, 3'd1, 1'b0);
        check_state("post_reset", 1, 0, 1);
        check("post_reset_lq", int'(bus.out_lqlist), 'h0A);
        pop1();
        check_state("post_reset_pop", 0, 1, 1);
        check("sb_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pdu_inbuf.md
Name: pdu_inbuf

Overview:
- Input buffer that feeds the PDU controller: the writer end of the to_pdubuf interface.
- Accepts instruction entries (opcode plus logical-qubit bitmask) from the upstream issue stage and stores them in a circular FIFO.
- Presents the head entry and an empty flag to the PDU. The PDU pops the head with take_in.
- Drops entries whose lqlist is zero. The PDU treats a zero next_lqlist as "last LQ" and must never receive an empty list.

Parameters:
- NUM_LQ, 8: number of logical qubits; width of the lqlist bitmask.
- LQADDR_BW, 3: width of an LQ index; equals ceil(log2(NUM_LQ)).
- OPCODE_BW, 4: opcode width.
- DEPTH, 4: number of FIFO entries; must be a power of two.
- PTR_BW, 2: pointer width; equals log2(DEPTH).

Ports:
- clk, input, 1: clock. Single clock domain.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: upstream entry valid.
- in_opcode, input, OPCODE_BW: upstream opcode.
- in_lqlist, input, NUM_LQ: upstream target-LQ bitmask.
- in_ready, output, 1: buffer can accept an entry this cycle.
- in_drop, output, 1: one-cycle pulse; an accepted entry had a zero lqlist and was discarded.
- take_in, input, 1: pop request from pdu_ctrl.
- to_pdubuf_empty, output, 1: FIFO holds no entries.
- out_opcode, output, OPCODE_BW: head-entry opcode.
- out_lqlist, output, NUM_LQ: head-entry lqlist.
- out_first_lqidx, output, LQADDR_BW: index of the lowest set bit of out_lqlist.
- count, output, PTR_BW+1: current occupancy, range 0 to DEPTH.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - wr_ptr, rd_ptr and count go to 0; all storage entries are cleared.
  - to_pdubuf_empty=1, in_ready=1, in_drop=0.
  - out_opcode, out_lqlist and out_first_lqidx are 0.
  - Reset asserted mid-operation discards all contents immediately.
- in_ready = (count != DEPTH). It depends only on registered state, never on take_in. There is no full-bypass.
- Accept: an entry is accepted when in_valid & in_ready.
  - Push: accept & (in_lqlist != 0). The entry is written at wr_ptr; wr_ptr increments modulo DEPTH.
  - Drop: accept & (in_lqlist == 0). Nothing is stored. in_drop=1 on the next cycle only.
  - A drop has in_ready=1 as a precondition, so nothing is dropped while the FIFO is full.
- Pop: take_in & ~to_pdubuf_empty. rd_ptr increments modulo DEPTH.
  - take_in while empty is ignored: no pointer or count change.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, both pointers advance.
  - The same-cycle rule also applies at count = DEPTH-1 and at count = 1.
- to_pdubuf_empty = (count == 0), registered-derived.
  - A push into an empty FIFO becomes visible on the next cycle (1-cycle write-to-read latency).
  - There is no same-cycle bypass from the input ports to the output ports.
- Head outputs are a combinational read of the entry at rd_ptr.
  - When empty, out_opcode, out_lqlist and out_first_lqidx are forced to 0.
- out_first_lqidx is a priority encode of out_lqlist: the lowest set bit wins. With a nonzero lqlist the result is always valid.
- Wrap-around: pointers wrap from DEPTH-1 to 0. Full and empty are distinguished by count, not by pointer equality.
- Entries leave in strict FIFO order. There is no reordering and no merging of entries.

Test Plan:
- Reset, then idle: to_pdubuf_empty=1, in_ready=1, count=0, all head outputs 0. take_in=1 while empty leaves count=0.
- Push opcode=3, lqlist=8'b0010_1000: on the next cycle to_pdubuf_empty=0, count=1, out_lqlist=0x28, out_first_lqidx=3. Then take_in for one cycle: empty=1, count=0.
- Push 4 entries with lqlists 0x01, 0x02, 0x04, 0x80 without popping: count=4, in_ready=0. A 5th in_valid is not accepted. Pops return 0x01, 0x02, 0x04, 0x80 in order, with first_lqidx 0, 1, 2, 7.
- Push with in_lqlist=0: in_drop=1 for exactly 1 cycle, count unchanged, empty unchanged.
- At count=4, assert take_in and in_valid together: the pop occurs and the push is refused (in_ready=0), so count=3. At count=2, push and pop together: count stays 2 and the pointers wrap correctly over 10 iterations, keeping FIFO order.
- With 3 entries held, pulse rst_n low asynchronously mid-cycle: outputs clear immediately, count=0, empty=1. The first push after reset is read back correctly.
